// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode 7-segment scanner with per-frame BCD snapshot and leading-zero blanking.
// Latency: outputs registered, 1 cycle from (cnt, slot, shadow); no backpressure, inputs sampled once per frame.
module bcd_scan_display #(
    parameter int NUM_DIGITS  = 5,
    parameter int REFRESH_DIV = 1000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
    localparam logic [SW-1:0] SLOT_MAX = SW'(NUM_DIGITS - 1);

    logic [CW-1:0]                r_cnt;
    logic [SW-1:0]                r_slot;
    logic                         r_load_pending;
    logic [NUM_DIGITS-1:0][3:0]   r_sh_dig;
    logic [NUM_DIGITS-1:0]        r_sh_dp;

    logic                         w_load;
    logic                         w_blank;
    logic [3:0]                   w_digit;
    logic [NUM_DIGITS-1:0]        w_zero_from;
    logic [NUM_DIGITS-1:0]        w_an_sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    assign w_load   = r_load_pending || ((r_cnt == CNT_MAX) && (r_slot == SLOT_MAX));
    assign w_digit  = r_sh_dig[r_slot];
    assign w_an_sel = ~(NUM_DIGITS'(1) << r_slot);

    // w_zero_from[i] is set when digits i..top are all zero; codes A..F count as non-zero.
    always_comb begin
        w_zero_from = '0;
        w_zero_from[NUM_DIGITS-1] = (r_sh_dig[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_zero_from[i] = w_zero_from[i+1] && (r_sh_dig[i] == 4'h0);
        end
    end

    assign w_blank = lz_en && (r_slot != '0) && w_zero_from[r_slot];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_slot         <= '0;
            r_load_pending <= 1'b1;
            r_sh_dig       <= '0;
            r_sh_dp        <= '0;
            an             <= '1;
            seg            <= 7'h7F;
            dp             <= 1'b1;
            frame_tick     <= 1'b0;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt  <= '0;
                r_slot <= (r_slot == SLOT_MAX) ? '0 : r_slot + SW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            r_load_pending <= 1'b0;
            frame_tick     <= w_load;
            if (w_load) begin
                r_sh_dig <= digits;
                r_sh_dp  <= dp_en;
            end

            // Ghost guard: anodes stay off at the start of every slot.
            if (r_cnt < CNT_DEAD) begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= w_an_sel;
                seg <= w_blank ? 7'h7F : seg_decode(w_digit);
                dp  <= ~r_sh_dp[r_slot];
            end
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: a reference model pushes expected outputs per cycle into a scoreboard
// queue, popped and compared after each edge, plus directed spot checks from the test plan.
module tb_bcd_scan_display;

    localparam int ND = 5;
    localparam int RD = 4;
    localparam int DC = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4*ND-1:0] digits = '0;
    logic [ND-1:0] dp_en = '0;
    logic          lz_en = 1'b0;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_tick;

    bcd_scan_display #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .dp_en     (dp_en),
        .lz_en     (lz_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        logic          ft;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    int            m_cnt, m_slot;
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0] m_dp;
    bit            m_lp;
    bit            last_ft;
    logic [6:0]    dec_tbl [16];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] ex);
        checks++;
        assert (obs === ex) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_slot = 0;
        m_dig  = '0;
        m_dp   = '0;
        m_lp   = 1'b1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [4*ND-1:0] upper;
        e.ft = m_lp || (m_cnt == RD - 1 && m_slot == ND - 1);
        if (m_cnt < DC) begin
            e.an  = '1;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an         = '1;
            e.an[m_slot] = 1'b0;
            upper        = m_dig >> (4 * m_slot);
            if (lz_en && m_slot > 0 && upper == '0) e.seg = 7'h7F;
            else                                    e.seg = dec_tbl[m_dig[4*m_slot +: 4]];
            e.dp = ~m_dp[m_slot];
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        e = model_out();
        sb.push_back(e);
        last_ft = e.ft;
        if (e.ft) begin
            m_dig = digits;
            m_dp  = dp_en;
        end
        m_lp = 1'b0;
        if (m_cnt == RD - 1) begin
            m_cnt  = 0;
            m_slot = (m_slot == ND - 1) ? 0 : m_slot + 1;
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_an",  8'(an),         8'(e.an));
        chk("sb_seg", 8'(seg),        8'(e.seg));
        chk("sb_dp",  8'(dp),         8'(e.dp));
        chk("sb_ft",  8'(frame_tick), 8'(e.ft));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model has performed a snapshot load (bounded).
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_ft && n < 60);
        checks++;
        if (!last_ft) begin
            failures++;
            $error("FAIL sync_frame observed=no_load expected=load_within_60");
        end
    endtask

    initial begin
        dec_tbl[0] = 7'h40; dec_tbl[1] = 7'h79; dec_tbl[2] = 7'h24; dec_tbl[3] = 7'h30;
        dec_tbl[4] = 7'h19; dec_tbl[5] = 7'h12; dec_tbl[6] = 7'h02; dec_tbl[7] = 7'h78;
        dec_tbl[8] = 7'h00; dec_tbl[9] = 7'h10;
        for (int i = 10; i < 16; i++) dec_tbl[i] = 7'h3F;
        model_reset();

        // 1. Reset state while clock runs
        #22;
        chk("rst_an",  8'(an),         8'h1F);
        chk("rst_seg", 8'(seg),        8'h7F);
        chk("rst_dp",  8'(dp),         8'h01);
        chk("rst_ft",  8'(frame_tick), 8'h00);

        // 2. Basic scan of 12345
        digits = 20'h12345;
        rst    = 1'b1;
        steps(1);
        chk("first_ft", 8'(frame_tick), 8'h01);
        steps(1);
        chk("s0_an",  8'(an),  8'h1E);
        chk("s0_seg", 8'(seg), 8'h12);
        chk("s0_ft",  8'(frame_tick), 8'h00);
        steps(4);
        chk("s1_an",  8'(an),  8'h1D);
        chk("s1_seg", 8'(seg), 8'h19);
        steps(12);
        chk("s4_an",  8'(an),  8'h0F);
        chk("s4_seg", 8'(seg), 8'h79);
        steps(4);
        chk("rep_an",  8'(an),  8'h1E);
        chk("rep_seg", 8'(seg), 8'h12);
        steps(20);

        // 3. Leading-zero blanking
        digits = 20'h00042;
        lz_en  = 1'b1;
        sync_frame();
        steps(2);
        chk("lz_s0_seg", 8'(seg), 8'h24);
        steps(4);
        chk("lz_s1_seg", 8'(seg), 8'h19);
        steps(4);
        chk("lz_s2_seg", 8'(seg), 8'h7F);
        steps(8);
        chk("lz_s4_seg", 8'(seg), 8'h7F);
        digits = 20'h00000;
        sync_frame();
        steps(2);
        chk("z_s0_seg", 8'(seg), 8'h40);
        steps(4);
        chk("z_s1_seg", 8'(seg), 8'h7F);
        lz_en = 1'b0;
        steps(1);
        chk("z_live_seg", 8'(seg), 8'h40);
        steps(16);

        // 4. Tearing guard
        digits = 20'h00009;
        sync_frame();
        steps(2);
        chk("tear_old_s0", 8'(seg), 8'h10);
        steps(8);
        digits = 20'h00010;
        steps(8);
        sync_frame();
        steps(2);
        chk("tear_new_s0", 8'(seg), 8'h40);
        steps(4);
        chk("tear_new_s1", 8'(seg), 8'h79);

        // 5. Invalid code and decimal point
        digits = 20'h00B00;
        dp_en  = 5'b00100;
        sync_frame();
        steps(2);
        chk("dp_s0_dp", 8'(dp), 8'h01);
        steps(8);
        chk("inv_s2_an",  8'(an),  8'h1B);
        chk("inv_s2_seg", 8'(seg), 8'h3F);
        chk("inv_s2_dp",  8'(dp),  8'h00);
        steps(3);
        chk("dead_an",  8'(an),  8'h1F);
        chk("dead_seg", 8'(seg), 8'h7F);
        chk("dead_dp",  8'(dp),  8'h01);

        // 6. Asynchronous reset mid-slot (cnt=2, slot=3)
        for (int i = 0; i < 40 && !(m_cnt == 2 && m_slot == 3); i++) step();
        chk("pre_rst_an", 8'(an), 8'h17);
        rst = 1'b0;
        #1;
        chk("arst_an",  8'(an),         8'h1F);
        chk("arst_seg", 8'(seg),        8'h7F);
        chk("arst_dp",  8'(dp),         8'h01);
        chk("arst_ft",  8'(frame_tick), 8'h00);
        model_reset();
        #2;
        rst = 1'b1;
        steps(1);
        chk("rel_ft", 8'(frame_tick), 8'h01);
        steps(1);
        chk("rel_s0_an",  8'(an),  8'h1E);
        chk("rel_s0_seg", 8'(seg), 8'h40);
        steps(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
